// File: rtl/demux_stream_1ton.sv
// demux_stream_1ton: registered 1-to-N valid/ready stream demux with packet lock and drop counter
//   clk, rst                           clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_sel/s_last input stream; s_sel picks the channel
//   m_valid[N_OUT]/m_ready[N_OUT]       per-channel handshake, one-hot valid
//   m_data/m_last                       shared payload, qualified by m_valid
//   pkt_busy                            inside a multi-beat packet (PKT_MODE=1)
//   drop_cnt                            saturating count of out-of-range beats
module demux_stream_1ton #(
  parameter int N_OUT = 4,
  parameter int SEL_W = 2,
  parameter int DATA_W = 8,
  parameter int PKT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SEL_W-1:0]  s_sel,
  input  logic              s_last,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              pkt_busy,
  output logic [15:0]       drop_cnt
);
  typedef enum logic {IDLE, IN_PKT} state_t;
  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_OUT);
  state_t state, state_nxt;
  logic out_vld, out_last, dst_rdy, accept, sel_ok, drain;
  logic [SEL_W-1:0] out_dst, lock_sel, eff_sel;
  logic [DATA_W-1:0] out_data;
  always_comb begin
    dst_rdy = 1'b0;
    m_valid = '0;
    for (int k = 0; k < N_OUT; k++) begin
      dst_rdy = dst_rdy | ((out_dst == SEL_W'(k)) && m_ready[k]);
      m_valid[k] = out_vld && (out_dst == SEL_W'(k));
    end
  end
  assign s_ready = !rst && (!out_vld || dst_rdy);
  assign accept = s_valid && s_ready;
  assign drain = out_vld && dst_rdy;
  assign eff_sel = (PKT_MODE != 0 && state == IN_PKT) ? lock_sel : s_sel;
  // one extra bit so N_OUT == 2**SEL_W does not wrap to zero
  assign sel_ok = {1'b0, eff_sel} < N_LIM;
  assign m_data = out_data;
  assign m_last = out_last;
  assign pkt_busy = state == IN_PKT;
  // every accepted beat ends the packet on s_last, otherwise it is (or stays) open
  always_comb state_nxt = (PKT_MODE != 0 && accept) ? (s_last ? IDLE : IN_PKT) : state;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dst <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      lock_sel <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept && state == IDLE && !s_last) lock_sel <= s_sel;
      if (accept && sel_ok) begin
        out_vld <= 1'b1;
        out_dst <= eff_sel;
        out_data <= s_data;
        out_last <= s_last;
      end else if (drain) out_vld <= 1'b0;
      if (accept && !sel_ok && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: doc/demux_stream_1ton.md
Name: demux_stream_1ton

Overview:
- Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake on every port. Successor to the combinational 2-to-4 demux.
- Routes each input beat to one of N_OUT output channels selected by s_sel.
- Optional packet mode locks the destination from the first beat to the s_last beat. Beats with an out-of-range select are dropped and counted.
- Sits between a single stream source and N downstream consumers.

Parameters:
- N_OUT, 4, number of output channels (2..16).
- SEL_W, 2, width of s_sel. Must satisfy 2**SEL_W >= N_OUT.
- DATA_W, 8, payload width.
- PKT_MODE, 1, 1 = select latched on the first beat and held until s_last; 0 = select sampled on every beat.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  DATA_W  input payload
- s_sel  in  SEL_W  destination channel index
- s_last  in  1  last beat of packet
- m_valid  out  N_OUT  one-hot per-channel valid
- m_ready  in  N_OUT  per-channel ready
- m_data  out  DATA_W  shared payload bus, qualified by m_valid
- m_last  out  1  shared last flag, qualified by m_valid
- pkt_busy  out  1  1 while in IN_PKT state
- drop_cnt  out  16  saturating count of dropped beats

Behaviour:
- Single output register holds out_vld, out_dst, out_data, out_last.
  - m_valid[k] = out_vld && (out_dst == k).
  - m_data = out_data, m_last = out_last.
- Handshake:
  - s_ready = !rst && (!out_vld || m_ready[out_dst]). Combinational from register state and m_ready only, never from s_valid.
  - accept = s_valid && s_ready.
  - Latency 1 cycle: a beat accepted in cycle t appears on m_* in cycle t+1. Throughput 1 beat/cycle with a ready sink.
- Output stability: while m_valid[k] && !m_ready[k], m_data, m_last and m_valid hold unchanged. Backpressure on the current destination stalls all input, including beats for other channels (no reordering).
- Effective select, eff_sel:
  - PKT_MODE=0: always s_sel.
  - PKT_MODE=1: s_sel in IDLE; lock_sel in IN_PKT.
- FSM, PKT_MODE=1 only:
  - IDLE, on accept && !s_last: lock_sel <= s_sel, go to IN_PKT.
  - IDLE, on accept && s_last: single-beat packet, stay in IDLE.
  - IN_PKT, on accept && s_last: go to IDLE.
  - s_sel is ignored in IN_PKT.
  - With PKT_MODE=0 the state stays IDLE permanently and pkt_busy = 0.
- Register update each cycle:
  - accept with eff_sel < N_OUT: load out_data, out_last, out_dst <= eff_sel; out_vld <= 1.
  - accept with eff_sel >= N_OUT: beat is dropped. It is consumed, not forwarded. drop_cnt increments, saturating at 16'hFFFF. out_vld <= 0 if the old beat drained this cycle, otherwise holds.
  - No accept and m_ready[out_dst]: out_vld <= 0.
- Invalid select in PKT_MODE=1: an invalid select latched on the first beat drops the whole packet, one drop_cnt increment per beat. The FSM still tracks s_last.
- Reset (synchronous, rst=1 at a clk edge):
  - Values: out_vld=0, out_dst=0, out_data=0, out_last=0, state=IDLE, lock_sel=0, drop_cnt=0.
  - Resulting outputs: m_valid=0, m_data=0, m_last=0, pkt_busy=0.
  - s_ready=0 while rst is high.
  - Mid-packet reset discards the held beat and the lock; the next beat after reset is treated as a first beat.
- Outputs are undefined-free: no X on any output after the first reset edge.

Test Plan:
- Reset then PKT_MODE=0, all m_ready=1; send data 8'hA0..8'hA3 with sel 0,1,2,3 on consecutive cycles -> m_valid = 0001,0010,0100,1000 on cycles t+1..t+4; m_data matches; s_ready stays 1.
- PKT_MODE=1; 3-beat packet sel=2 (data 11,22,33, last on 33), s_sel changed to 0 on beats 2-3 -> all three beats on m_valid=0100; pkt_busy=1 after beat 1 and 0 after beat 3.
- Backpressure: beat for ch1 with m_ready=0000 for 3 cycles -> m_valid=0010 and m_data stable for 3 cycles, s_ready=0; next beat for ch3 waits; raise m_ready[1] -> ch1 beat drains, ch3 beat appears the following cycle.
- N_OUT=3, SEL_W=2, s_sel=3 for 2 beats -> m_valid stays 000, s_ready=1, drop_cnt = 2.
- Assert rst mid-packet with a held output beat -> next cycle m_valid=0, pkt_busy=0, drop_cnt=0, s_ready=0 during rst; after release a beat with sel=1 routes to ch1 (lock cleared).
- Saturation: force 65537 invalid beats -> drop_cnt holds 16'hFFFF.
